mult_share_arb: RTL and testbench

- Time-shares one 4x4 unsigned array multiplier between NUM_REQ requesters.
- Each requester uses a valid/ready handshake on its operand port. A round-robin arbiter picks one request at a time.
- The block registers the operands, registers the 8-bit product and returns it on a single response port tagged with the requester index.
- It sits between the operand producers and the shared multiplier datapath.

---
 rtl/mult_share_pkg.sv | 13 +
 rtl/mult_share_arb_mul4x4.sv | 20 ++
 rtl/mult_share_arb_rr_arbiter.sv | 31 +++
 rtl/mult_share_arb.sv | 119 +++++++++++
 tb/tb_mult_share_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types and widths for the time-shared multiplier
package mult_share_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mult_share_arb_mul4x4.sv
// rtl/mult_share_arb_mul4x4.sv - combinational unsigned array multiplier
module mul4x4
    import mult_share_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] y
);

    // Shift-and-add of the partial-product rows; full product width, no truncation.
    always_comb begin
        y = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) begin
                y = y + (PROD_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// rtl/mult_share_arb_rr_arbiter.sv - combinational rotating-priority arbiter
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Search starts just after the last winner and wraps, so the last winner is tried last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin shared 4x4 multiplier; optional MULT_SHARE_ARB_STATS_EN counters
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [OP_W*NUM_REQ-1:0] req_a,
    input  logic [OP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PROD_W-1:0]       rsp_y,
    output logic [ID_W-1:0]         rsp_id,
`ifdef MULT_SHARE_ARB_STATS_EN
    output logic [15:0]             grant_cnt,
    output logic [15:0]             stall_cnt,
`endif
    output logic                    busy
);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_r;
    logic [ID_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic [OP_W-1:0]     a_sel;
    logic [OP_W-1:0]     b_sel;
    logic [PROD_W-1:0]   prod;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    mul4x4 u_mul (
        .a (op_a),
        .b (op_b),
        .y (prod)
    );

    // Grant is offered only while idle and out of reset.
    assign req_ready = (rst_n && state == ST_IDLE) ? gnt : '0;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*OP_W +: OP_W];
                b_sel = req_b[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            id_r      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
`ifdef MULT_SHARE_ARB_STATS_EN
            grant_cnt <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        op_a   <= a_sel;
                        op_b   <= b_sel;
                        id_r   <= gnt_idx;
                        rr_ptr <= gnt_idx;
                        state  <= ST_MUL;
`ifdef MULT_SHARE_ARB_STATS_EN
                        grant_cnt <= grant_cnt + 16'd1;
`endif
                    end
                end
                ST_MUL: begin
                    rsp_y     <= prod;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
`ifdef MULT_SHARE_ARB_STATS_EN
                    else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb
module tb_mult_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_y;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic [15:0]          grant_cnt;
    logic [15:0]          stall_cnt;
`endif

    mult_share_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
`ifdef MULT_SHARE_ARB_STATS_EN
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      y;
    } exp_t;

    exp_t             exp_q[$];
    int               grant_log[$];
    logic [NUM_REQ-1:0] acc_vec = '0;
    int               n_grants = 0;
    int               n_rsp = 0;
    int               n_checks = 0;
    int               n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: push expectations on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        acc_vec = req_valid & req_ready;
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_vec[i]) begin
                    exp_t e;
                    e.id = ID_W'(i);
                    e.y  = 8'(req_a[i*4 +: 4]) * 8'(req_b[i*4 +: 4]);
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                    n_grants++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                check("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_y", 32'(rsp_y), 32'(e.y));
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic grant_one(input string tag, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] exp_rdy);
        @(posedge clk); #1;
        req_valid = v;
        @(negedge clk);
        check(tag, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int snap;
        bit seen;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = 16'h9F37;
        req_b     = 16'h5CE2;
        rsp_ready = 1'b1;

        // Reset held with every requester valid
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_y", 32'(rsp_y), 0);
            check("rst_busy", 32'(busy), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with all requesters valid
        for (int c = 0; c < 100 && grant_log.size() < 6; c++) @(negedge clk);
        check("rr_six_grants", 32'(grant_log.size() >= 6), 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("rr_idle");
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check($sformatf("rr_order%0d", i), 32'(grant_log[i]), 32'(i % 4));
        end

        // Single request, max operands, latency
        req_a[11:8] = 4'hF;
        req_b[11:8] = 4'hF;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("single_mul_valid", 32'(rsp_valid), 0);
        check("single_mul_busy", 32'(busy), 1);
        check("single_mul_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 1);
        check("single_y", 32'(rsp_y), 32'd225);
        check("single_id", 32'(rsp_id), 2);
        wait_idle("single_idle");

        // Backpressure: requester 3 wins (last grant was 2), a3*b3 = 9*5
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_rsp_seen", 32'(seen), 1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_y", 32'(rsp_y), 32'd45);
            check("bp_id", 32'(rsp_id), 3);
            check("bp_no_grant", 32'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h1);
        check("bp_rsp_done", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("bp_idle");

        // Wrap and sparse requests
        grant_one("sparse_g3", 4'b1000, 4'b1000);
        grant_one("sparse_g1", 4'b0010, 4'b0010);
        grant_one("sparse_wrap0", 4'b0011, 4'b0001);

        // Random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc_vec[i]) begin
                    req_valid[i]    = 1'($urandom_range(0, 1));
                    req_a[i*4 +: 4] = 4'($urandom);
                    req_b[i*4 +: 4] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("rand_idle");
        check("rand_drained", 32'(exp_q.size()), 0);
        check("rand_rsp_count", 32'(n_rsp > 40), 1);
`ifdef MULT_SHARE_ARB_STATS_EN
        check("stats_grant_cnt", 32'(grant_cnt), 32'(n_grants));
`endif

        // Reset while in MUL discards the product
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        n_grants = 0;
        @(negedge clk);
        check("midrst_in_mul", 32'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(rsp_valid), 0);
        check("midrst_idle", 32'(busy), 0);
`ifdef MULT_SHARE_ARB_STATS_EN
        check("midrst_grant_cnt", 32'(grant_cnt), 0);
`endif
        snap = n_rsp;
        repeat (10) @(negedge clk);
        check("midrst_no_rsp", 32'(n_rsp), 32'(snap));

        // Pointer restarts at requester 0 after reset
        grant_one("postrst_grant0", 4'b1111, 4'b0001);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
